// File: rtl/itlb_sa_if.sv
// PTE fetch channel between the ITLB and the AXI read master.
interface itlb_sa_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  ADDR_TO_AXIM_VALID;
   logic [ADDR_WIDTH-1:0] ADDR_TO_AXIM;
   logic                  DATA_FROM_AXIM_VALID;
   logic [DATA_WIDTH-1:0] DATA_FROM_AXIM;

   modport master (
      output ADDR_TO_AXIM_VALID, ADDR_TO_AXIM,
      input  DATA_FROM_AXIM_VALID, DATA_FROM_AXIM
   );

   modport slave (
      input  ADDR_TO_AXIM_VALID, ADDR_TO_AXIM,
      output DATA_FROM_AXIM_VALID, DATA_FROM_AXIM
   );
endinterface

// File: rtl/itlb_sa.sv
// Set-associative ASID-tagged instruction TLB with single-level PTE refill,
// per-set round-robin replacement, bare-mode bypass and page-fault reporting.
module itlb_sa #(
   parameter int unsigned ADDR_WIDTH        = 32,
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned PAGE_OFFSET_WIDTH = 12,
   parameter int unsigned PPN_LEN           = 22,
   parameter int unsigned ASID_LEN          = 9,
   parameter int unsigned TLB_SETS          = 64,
   parameter int unsigned TLB_WAYS          = 4,
   parameter int unsigned PTESIZE           = 4,
   parameter logic [ADDR_WIDTH-1:0] VIRT_ADDR_INIT = 32'h0001_0000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  TLB_FLUSH,
   input  logic [DATA_WIDTH-1:0] SATP,
   input  logic [ADDR_WIDTH-1:0] VIRT_ADDR,
   input  logic                  VIRT_ADDR_VALID,
   input  logic                  CACHE_READY,
   output logic [ADDR_WIDTH-1:0] CURR_ADDR,
   output logic                  PHY_ADDR_VALID,
   output logic [ADDR_WIDTH-1:0] PHY_ADDR,
   itlb_sa_if.master             axi,
   output logic                  PAGE_FAULT,
   output logic [ADDR_WIDTH-1:0] PAGE_FAULT_ADDR,
   input  logic                  FAULT_ACK
);
   localparam int unsigned IDX_W = $clog2(TLB_SETS);
   localparam int unsigned TAG_W = ADDR_WIDTH - PAGE_OFFSET_WIDTH - IDX_W;
   localparam int unsigned VPN_W = ADDR_WIDTH - PAGE_OFFSET_WIDTH;
   localparam int unsigned WAY_W = (TLB_WAYS > 1) ? $clog2(TLB_WAYS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_FAULT} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   virt_addr_q, virt_addr_d;
   logic                    axim_valid_q, axim_valid_d;
   logic [ADDR_WIDTH-1:0]   axim_addr_q, axim_addr_d;
   logic                    fault_q, fault_d;
   logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;
   logic                    discard_q, discard_d;
   logic                    fill_g_q, fill_g_d;
   logic [PPN_LEN-1:0]      fill_ppn_q, fill_ppn_d;

   logic [TLB_WAYS-1:0]     valid_q [TLB_SETS];
   logic [TLB_WAYS-1:0]     valid_d [TLB_SETS];
   logic [WAY_W-1:0]        rr_q    [TLB_SETS];
   logic [WAY_W-1:0]        rr_d    [TLB_SETS];
   logic [TLB_WAYS-1:0]     g_q     [TLB_SETS];
   logic [TLB_WAYS-1:0]     g_d     [TLB_SETS];
   logic [TAG_W-1:0]        tag_q   [TLB_SETS][TLB_WAYS];
   logic [TAG_W-1:0]        tag_d   [TLB_SETS][TLB_WAYS];
   logic [ASID_LEN-1:0]     asid_q  [TLB_SETS][TLB_WAYS];
   logic [ASID_LEN-1:0]     asid_d  [TLB_SETS][TLB_WAYS];
   logic [PPN_LEN-1:0]      ppn_q   [TLB_SETS][TLB_WAYS];
   logic [PPN_LEN-1:0]      ppn_d   [TLB_SETS][TLB_WAYS];

   logic [IDX_W-1:0]        idx;
   logic [TAG_W-1:0]        tag;
   logic [VPN_W-1:0]        vpn;
   logic                    satp_mode;
   logic [ASID_LEN-1:0]     satp_asid;
   logic [PPN_LEN-1:0]      satp_ppn;
   logic                    hit;
   logic [WAY_W-1:0]        hit_way;
   logic [ADDR_WIDTH-1:0]   trans_addr;
   logic [ADDR_WIDTH-1:0]   pte_addr;
   logic                    pte_bad;
   logic                    phy_valid_c;
   logic [WAY_W-1:0]        rr_cur;

   assign idx       = virt_addr_q[PAGE_OFFSET_WIDTH +: IDX_W];
   assign tag       = virt_addr_q[ADDR_WIDTH-1 -: TAG_W];
   assign vpn       = virt_addr_q[ADDR_WIDTH-1 -: VPN_W];
   assign satp_mode = SATP[DATA_WIDTH-1];
   assign satp_asid = SATP[PPN_LEN +: ASID_LEN];
   assign satp_ppn  = SATP[PPN_LEN-1:0];
   assign rr_cur    = rr_q[idx];

   // Scan high to low so the lowest-numbered hitting way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = TLB_WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag) &&
             (g_q[idx][w] || (asid_q[idx][w] == satp_asid))) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign trans_addr  = ADDR_WIDTH'({ppn_q[idx][hit_way], virt_addr_q[PAGE_OFFSET_WIDTH-1:0]});
   assign pte_addr    = ADDR_WIDTH'({satp_ppn, PAGE_OFFSET_WIDTH'(0)})
                      + ADDR_WIDTH'(vpn) * ADDR_WIDTH'(PTESIZE);
   assign pte_bad     = !axi.DATA_FROM_AXIM[0] || !axi.DATA_FROM_AXIM[3] ||
                        (axi.DATA_FROM_AXIM[2] && !axi.DATA_FROM_AXIM[1]);
   assign phy_valid_c = (state_q == S_IDLE) && (!satp_mode || hit);

   assign CURR_ADDR              = virt_addr_q;
   assign PHY_ADDR_VALID         = phy_valid_c;
   assign PHY_ADDR               = satp_mode ? trans_addr : virt_addr_q;
   assign axi.ADDR_TO_AXIM_VALID = axim_valid_q;
   assign axi.ADDR_TO_AXIM       = axim_addr_q;
   assign PAGE_FAULT             = fault_q;
   assign PAGE_FAULT_ADDR        = fault_addr_q;

   always_comb begin
      state_d      = state_q;
      virt_addr_d  = virt_addr_q;
      axim_valid_d = 1'b0;
      axim_addr_d  = axim_addr_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      discard_d    = discard_q;
      fill_g_d     = fill_g_q;
      fill_ppn_d   = fill_ppn_q;
      valid_d      = valid_q;
      rr_d         = rr_q;
      g_d          = g_q;
      tag_d        = tag_q;
      asid_d       = asid_q;
      ppn_d        = ppn_q;

      if (phy_valid_c && VIRT_ADDR_VALID && CACHE_READY) virt_addr_d = VIRT_ADDR;

      case (state_q)
         S_IDLE: begin
            discard_d = 1'b0;
            if (satp_mode && !hit && !TLB_FLUSH) begin
               state_d      = S_REQ;
               axim_valid_d = 1'b1;
               axim_addr_d  = pte_addr;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
            if (TLB_FLUSH) discard_d = 1'b1;
         end
         // A flush while the PTE is in flight makes the response stale.
         S_WAIT: begin
            if (TLB_FLUSH) discard_d = 1'b1;
            if (axi.DATA_FROM_AXIM_VALID) begin
               discard_d = 1'b0;
               if (discard_q || TLB_FLUSH) begin
                  state_d = S_IDLE;
               end else if (pte_bad) begin
                  state_d      = S_FAULT;
                  fault_d      = 1'b1;
                  fault_addr_d = virt_addr_q;
               end else begin
                  state_d    = S_FILL;
                  fill_g_d   = axi.DATA_FROM_AXIM[5];
                  fill_ppn_d = axi.DATA_FROM_AXIM[10 +: PPN_LEN];
               end
            end
         end
         S_FILL: begin
            state_d                = S_IDLE;
            valid_d[idx][rr_cur]   = 1'b1;
            g_d[idx][rr_cur]       = fill_g_q;
            tag_d[idx][rr_cur]     = tag;
            asid_d[idx][rr_cur]    = satp_asid;
            ppn_d[idx][rr_cur]     = fill_ppn_q;
            rr_d[idx]              = (rr_cur == WAY_W'(TLB_WAYS - 1)) ? '0 : rr_cur + WAY_W'(1);
         end
         S_FAULT: begin
            if (FAULT_ACK) begin
               fault_d = 1'b0;
               state_d = S_IDLE;
               if (VIRT_ADDR_VALID) virt_addr_d = VIRT_ADDR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush overrides any fill in the same cycle.
      if (TLB_FLUSH) begin
         for (int s = 0; s < TLB_SETS; s++) begin
            valid_d[s] = '0;
            rr_d[s]    = '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         virt_addr_q  <= VIRT_ADDR_INIT;
         axim_valid_q <= 1'b0;
         axim_addr_q  <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         discard_q    <= 1'b0;
         for (int s = 0; s < TLB_SETS; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         state_q      <= state_d;
         virt_addr_q  <= virt_addr_d;
         axim_valid_q <= axim_valid_d;
         axim_addr_q  <= axim_addr_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         discard_q    <= discard_d;
         valid_q      <= valid_d;
         rr_q         <= rr_d;
      end
   end

   // Entry payload needs no reset; it is qualified by valid.
   always_ff @(posedge CLK) begin
      fill_g_q   <= fill_g_d;
      fill_ppn_q <= fill_ppn_d;
      g_q        <= g_d;
      tag_q      <= tag_d;
      asid_q     <= asid_d;
      ppn_q      <= ppn_d;
   end
endmodule
